// File: rtl/l2_noc_pkg.sv
// Shared NoC header layout, assembler FSM states and message-type codes
// used by the L2 NoC front ends.
package l2_noc_pkg;

   localparam int LEN_HI  = 29;
   localparam int LEN_LO  = 22;
   localparam int TYPE_HI = 21;
   localparam int TYPE_LO = 14;
   localparam int MSHR_HI = 13;
   localparam int MSHR_LO = 6;
   localparam int SRCX_HI = 49;
   localparam int SRCX_LO = 42;
   localparam int SRCY_HI = 41;
   localparam int SRCY_LO = 34;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DRAIN,
      ST_FULL
   } asm_state_t;

   localparam logic [7:0] MSG_TYPE_DATA_ACK  = 8'd24;
   localparam logic [7:0] MSG_TYPE_NODATA_ACK = 8'd25;
   localparam logic [7:0] MSG_TYPE_WB_REQ    = 8'd12;
   localparam logic [7:0] MSG_TYPE_WBGUARD   = 8'd13;

endpackage

// File: rtl/l2_noc3_hdr_decode.sv
// Combinational slicing of a NoC header flit into its fields.
// Shared between the NoC1 and NoC3 front ends.
module l2_noc3_hdr_decode
   import l2_noc_pkg::*;
(
   input  logic [63:0] flit,
   output logic [7:0]  len,
   output logic [7:0]  msg_type,
   output logic [7:0]  mshrid,
   output logic [7:0]  src_x,
   output logic [7:0]  src_y
);

   assign len      = flit[LEN_HI:LEN_LO];
   assign msg_type = flit[TYPE_HI:TYPE_LO];
   assign mshrid   = flit[MSHR_HI:MSHR_LO];
   assign src_x    = flit[SRCX_HI:SRCX_LO];
   assign src_y    = flit[SRCY_HI:SRCY_LO];

   // Routing/option bits are not needed by the L2 pipe
   logic unused_hdr_bits;
   assign unused_hdr_bits = ^{flit[63:SRCX_HI+1],
                              flit[SRCY_LO-1:LEN_HI+1],
                              flit[MSHR_LO-1:0]};

endmodule

// File: rtl/l2_noc3_msg_assembler.sv
// Collects a NoC3 header/address/data flit stream into one parallel
// message for pipe2 S1; holds a single message and stalls NoC3 meanwhile.
module l2_noc3_msg_assembler
   import l2_noc_pkg::*;
#(
   parameter int MAX_DATA_FLITS = 2,
   parameter int ADDR_WIDTH     = 40
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [63:0]                  noc3_data_in,
   input  logic                         noc3_valid_in,
   output logic                         noc3_ready_in,
   output logic                         msg_valid,
   input  logic                         msg_ready,
   output logic [7:0]                   msg_type,
   output logic [7:0]                   msg_mshrid,
   output logic [7:0]                   msg_src_x,
   output logic [7:0]                   msg_src_y,
   output logic [ADDR_WIDTH-1:0]        msg_addr,
   output logic [64*MAX_DATA_FLITS-1:0] msg_data,
   output logic [1:0]                   msg_data_flits,
   output logic                         msg_len_err
);

   asm_state_t state;

   logic [7:0] rem;
   logic [7:0] type_q;
   logic [7:0] mshrid_q;
   logic [7:0] src_x_q;
   logic [7:0] src_y_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [MAX_DATA_FLITS-1:0][63:0] data_q;
   logic [1:0] cnt;
   logic err_q;

   logic [7:0] hdr_len;
   logic [7:0] hdr_type;
   logic [7:0] hdr_mshrid;
   logic [7:0] hdr_src_x;
   logic [7:0] hdr_src_y;

   l2_noc3_hdr_decode u_hdr (
      .flit     (noc3_data_in),
      .len      (hdr_len),
      .msg_type (hdr_type),
      .mshrid   (hdr_mshrid),
      .src_x    (hdr_src_x),
      .src_y    (hdr_src_y)
   );

   logic       hs;
   logic [7:0] rem_dec;
   logic [1:0] cnt_inc;

   assign noc3_ready_in = (state != ST_FULL);
   assign msg_valid     = (state == ST_FULL);
   assign hs            = noc3_valid_in && noc3_ready_in;
   // Saturating so a stray decrement can never wrap the counter
   assign rem_dec       = (rem == 8'd0) ? 8'd0 : rem - 8'd1;
   assign cnt_inc       = cnt + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rem      <= '0;
         type_q   <= '0;
         mshrid_q <= '0;
         src_x_q  <= '0;
         src_y_q  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (hs) begin
                  type_q   <= hdr_type;
                  mshrid_q <= hdr_mshrid;
                  src_x_q  <= hdr_src_x;
                  src_y_q  <= hdr_src_y;
                  addr_q   <= '0;
                  data_q   <= '0;
                  cnt      <= '0;
                  err_q    <= 1'b0;
                  rem      <= hdr_len;
                  state    <= (hdr_len == 8'd0) ? ST_FULL : ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (hs) begin
                  addr_q <= noc3_data_in[ADDR_WIDTH-1:0];
                  rem    <= rem_dec;
                  state  <= (rem_dec == 8'd0) ? ST_FULL : ST_DATA;
               end
            end
            ST_DATA: begin
               if (hs) begin
                  for (int i = 0; i < MAX_DATA_FLITS; i++) begin
                     if (cnt == 2'(i)) data_q[i] <= noc3_data_in;
                  end
                  cnt <= cnt_inc;
                  rem <= rem_dec;
                  if (rem_dec == 8'd0) begin
                     state <= ST_FULL;
                  end else if (cnt_inc == 2'(MAX_DATA_FLITS)) begin
                     err_q <= 1'b1;
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (hs) begin
                  rem <= rem_dec;
                  if (rem_dec == 8'd0) state <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (msg_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign msg_type       = type_q;
   assign msg_mshrid     = mshrid_q;
   assign msg_src_x      = src_x_q;
   assign msg_src_y      = src_y_q;
   assign msg_addr       = addr_q;
   assign msg_data       = data_q;
   assign msg_data_flits = cnt;
   assign msg_len_err    = err_q;

endmodule

// File: tb/tb_l2_noc3_msg_assembler.sv
// Directed and scoreboarded bench for the NoC3 message assembler.
module tb_l2_noc3_msg_assembler;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [63:0]  noc3_data_in = '0;
   logic         noc3_valid_in = 1'b0;
   logic         noc3_ready_in;
   logic         msg_valid;
   logic         msg_ready = 1'b0;
   logic [7:0]   msg_type;
   logic [7:0]   msg_mshrid;
   logic [7:0]   msg_src_x;
   logic [7:0]   msg_src_y;
   logic [39:0]  msg_addr;
   logic [127:0] msg_data;
   logic [1:0]   msg_data_flits;
   logic         msg_len_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   l2_noc3_msg_assembler #(
      .MAX_DATA_FLITS (2),
      .ADDR_WIDTH     (40)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .noc3_data_in   (noc3_data_in),
      .noc3_valid_in  (noc3_valid_in),
      .noc3_ready_in  (noc3_ready_in),
      .msg_valid      (msg_valid),
      .msg_ready      (msg_ready),
      .msg_type       (msg_type),
      .msg_mshrid     (msg_mshrid),
      .msg_src_x      (msg_src_x),
      .msg_src_y      (msg_src_y),
      .msg_addr       (msg_addr),
      .msg_data       (msg_data),
      .msg_data_flits (msg_data_flits),
      .msg_len_err    (msg_len_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [202:0] obs;
   assign obs = {msg_type, msg_mshrid, msg_src_x, msg_src_y,
                 msg_addr, msg_data, msg_data_flits, msg_len_err};

   function automatic logic [63:0] mk_hdr(input logic [7:0] len,
                                          input logic [7:0] typ,
                                          input logic [7:0] mshr,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
      logic [63:0] h;
      h = '0;
      h[29:22] = len;
      h[21:14] = typ;
      h[13:6]  = mshr;
      h[49:42] = x;
      h[41:34] = y;
      return h;
   endfunction

   // Presents one flit from a negedge until it is accepted; returns the
   // cycle number of the accepting edge.
   task automatic send(input logic [63:0] f, output int edge_n);
      int n;
      logic ok;
      n = 0;
      noc3_valid_in = 1'b1;
      noc3_data_in  = f;
      do begin
         ok = noc3_ready_in;
         @(negedge clk);
         n++;
      end while (!ok && n < 40);
      noc3_valid_in = 1'b0;
      noc3_data_in  = {$urandom, $urandom};
      edge_n = cyc;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: ready=%0b required 1", noc3_ready_in);
      end
   endtask

   task automatic get_msg();
      int n;
      n = 0;
      while (!msg_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      msg_ready = 1'b1;
      @(negedge clk);
      msg_ready = 1'b0;
      n_cmp++;
      if (msg_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL msg_handshake: valid=%0b required 0", msg_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (noc3_ready_in !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_ready: got %0b required 1", noc3_ready_in);
      end
      n_cmp++;
      if (msg_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_valid: got %0b required 0", msg_valid);
      end
      n_cmp++;
      if (obs !== '0) begin
         n_bad++;
         $display("FAIL rst_fields: got %h required 0", obs);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      int e;
      send(mk_hdr(8'd3, 8'h0C, 8'h01, 8'h01, 8'h01), e);
      send(64'h0000_0000_0000_1000, e);
      send(64'h0123_4567_89AB_CDEF, e);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (msg_valid !== 1'b0 || noc3_ready_in !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_async: valid=%0b ready=%0b required 0/1",
                  msg_valid, noc3_ready_in);
      end
      @(negedge clk);
      n_cmp++;
      if (msg_data_flits !== 2'd0 || msg_data !== '0) begin
         n_bad++;
         $display("FAIL midrst_clear: cnt=%0d data=%h required 0/0",
                  msg_data_flits, msg_data);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (msg_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_spurious: valid=%0b required 0", msg_valid);
         end
      end
      send(mk_hdr(8'd2, 8'h18, 8'h33, 8'h04, 8'h05), e);
      send(64'hF000_00AB_CDEF_0120, e);
      send(64'hCAFE_F00D_1234_5678, e);
      n_cmp++;
      if (msg_valid !== 1'b1 ||
          obs !== {8'h18, 8'h33, 8'h04, 8'h05, 40'hAB_CDEF_0120,
                   64'h0, 64'hCAFE_F00D_1234_5678, 2'd1, 1'b0}) begin
         n_bad++;
         $display("FAIL midrst_clean: valid=%0b got %h", msg_valid, obs);
      end
      get_msg();
   endtask

   task automatic test_header_only();
      int e;
      send(mk_hdr(8'd0, 8'h12, 8'h05, 8'h01, 8'h02), e);
      n_cmp++;
      if (msg_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL hdr_only_latency: valid=%0b required 1", msg_valid);
      end
      n_cmp++;
      if (obs !== {8'h12, 8'h05, 8'h01, 8'h02, 40'h0, 128'h0,
                   2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL hdr_only_fields: got %h", obs);
      end
      get_msg();
   endtask

   task automatic test_writeback();
      int e0;
      int e;
      send(mk_hdr(8'd3, 8'h0C, 8'h07, 8'h0A, 8'h0B), e0);
      send(64'hFF00_0012_3456_7880, e);
      send(64'hAAAA_AAAA_AAAA_AAAA, e);
      n_cmp++;
      if (msg_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL wb_early_valid: valid=%0b required 0", msg_valid);
      end
      send(64'h5555_5555_5555_5555, e);
      n_cmp++;
      if (e - e0 !== 3 || msg_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL wb_latency: span=%0d valid=%0b required 3/1",
                  e - e0, msg_valid);
      end
      n_cmp++;
      if (obs !== {8'h0C, 8'h07, 8'h0A, 8'h0B, 40'h12_3456_7880,
                   64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA,
                   2'd2, 1'b0}) begin
         n_bad++;
         $display("FAIL wb_fields: got %h", obs);
      end
      get_msg();
   endtask

   task automatic test_overflow();
      int e0;
      int e;
      send(mk_hdr(8'd5, 8'h18, 8'h09, 8'h02, 8'h03), e0);
      send(64'h0000_0001_0000_0040, e);
      send(64'h1111_1111_1111_1111, e);
      send(64'h2222_2222_2222_2222, e);
      send(64'h3333_3333_3333_3333, e);
      n_cmp++;
      if (msg_valid !== 1'b0 || noc3_ready_in !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_drain: valid=%0b ready=%0b required 0/1",
                  msg_valid, noc3_ready_in);
      end
      send(64'h4444_4444_4444_4444, e);
      n_cmp++;
      if (e - e0 !== 5 || msg_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_latency: span=%0d valid=%0b required 5/1",
                  e - e0, msg_valid);
      end
      n_cmp++;
      if (obs !== {8'h18, 8'h09, 8'h02, 8'h03, 40'h01_0000_0040,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111,
                   2'd2, 1'b1}) begin
         n_bad++;
         $display("FAIL ovf_fields: got %h", obs);
      end
      get_msg();
   endtask

   task automatic test_backpressure();
      int e;
      logic [202:0] exp;
      exp = {8'h21, 8'h01, 8'h06, 8'h07, 40'h00_0000_0040, 128'h0,
             2'd0, 1'b0};
      send(mk_hdr(8'd1, 8'h21, 8'h01, 8'h06, 8'h07), e);
      send(64'h0000_0000_0000_0040, e);
      noc3_valid_in = 1'b1;
      noc3_data_in  = mk_hdr(8'd1, 8'h22, 8'h02, 8'h08, 8'h09);
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (noc3_ready_in !== 1'b0 || msg_valid !== 1'b1 || obs !== exp) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: ready=%0b valid=%0b got %h",
                     i, noc3_ready_in, msg_valid, obs);
         end
         @(negedge clk);
      end
      msg_ready = 1'b1;
      @(negedge clk);
      msg_ready = 1'b0;
      n_cmp++;
      if (msg_valid !== 1'b0 || noc3_ready_in !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_release: valid=%0b ready=%0b required 0/1",
                  msg_valid, noc3_ready_in);
      end
      @(negedge clk);
      noc3_data_in = 64'h0000_0000_0000_0080;
      @(negedge clk);
      noc3_valid_in = 1'b0;
      n_cmp++;
      if (msg_valid !== 1'b1 ||
          obs !== {8'h22, 8'h02, 8'h08, 8'h09, 40'h00_0000_0080, 128'h0,
                   2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL bp_next_hdr: valid=%0b got %h", msg_valid, obs);
      end
      get_msg();
   endtask

   task automatic test_bubbly();
      int e;
      int len;
      logic [63:0] f [0:5];
      logic [202:0] exp;
      logic [39:0] ea;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [1:0] ec;
      for (int m = 0; m < 100; m++) begin
         len = $urandom_range(0, 5);
         f[0] = mk_hdr(8'(len), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom));
         for (int i = 1; i < 6; i++) f[i] = {$urandom, $urandom};
         ea = (len >= 1) ? f[1][39:0] : 40'h0;
         d0 = (len >= 2) ? f[2] : 64'h0;
         d1 = (len >= 3) ? f[3] : 64'h0;
         ec = (len >= 3) ? 2'd2 : (len == 2) ? 2'd1 : 2'd0;
         exp = {f[0][21:14], f[0][13:6], f[0][49:42], f[0][41:34],
                ea, d1, d0, ec, (len > 3)};
         for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 2)) begin
               noc3_valid_in = 1'b0;
               noc3_data_in  = {$urandom, $urandom};
               msg_ready     = 1'($urandom);
               @(negedge clk);
            end
            msg_ready = 1'b0;
            send(f[i], e);
         end
         n_cmp++;
         if (msg_valid !== 1'b1 || obs !== exp) begin
            n_bad++;
            $display("FAIL bubbly[%0d] L=%0d: valid=%0b got %h exp %h",
                     m, len, msg_valid, obs, exp);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         get_msg();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_header_only();
      test_mid_reset();
      test_writeback();
      test_overflow();
      test_backpressure();
      test_bubbly();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
